// File: rtl/tick_period_monitor_if.sv
// Tick-monitor port bundle: the tick stream in, lock status and measured period out.
// The lost pulse exists only when TICK_MON_TIMEOUT_EN is defined.
interface tick_period_monitor_if #(
  parameter int CNT_W = 4
);
  logic             tick_in;
  logic             locked;
  logic             period_err;
  logic [CNT_W-1:0] period_out;
`ifdef TICK_MON_TIMEOUT_EN
  logic             lost;

  modport master (output tick_in, input  locked, period_err, period_out, lost);
  modport slave  (input  tick_in, output locked, period_err, period_out, lost);
`else
  modport master (output tick_in, input  locked, period_err, period_out);
  modport slave  (input  tick_in, output locked, period_err, period_out);
`endif
endinterface

// File: rtl/tick_period_monitor.sv
// Measures the spacing of a one-cycle tick stream and locks after LOCK_COUNT equal periods.
// Optional feature macro: TICK_MON_TIMEOUT_EN (drop to IDLE and pulse lost when ticks stop).
module tick_period_monitor #(
  parameter int CNT_W      = 4,
  parameter int LOCK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tick_period_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       LOCK_N  = 3'(LOCK_COUNT);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] ref_q,    ref_d;
  logic [2:0]       match_q,  match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             locked_q, locked_d;
  logic             err_q,    err_d;

  logic             tick;
  logic             meas_valid;
  logic [2:0]       match_next;

  assign tick       = mon.tick_in;
  // A saturated count means the gap was too long to measure.
  assign meas_valid = (cnt_q != CNT_MAX);

`ifdef TICK_MON_TIMEOUT_EN
  logic lost_q, lost_d;
  logic timeout;

  // Fires on the edge that would push cnt into saturation with no tick.
  assign timeout = !tick && (state_q != ST_IDLE) && (cnt_q == CNT_MAX - CNT_ONE);
`endif

  // Period counter: restarts at 1 on every tick so it reads the period at the next tick.
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    match_d    = match_q;
    period_d   = period_q;
    match_next = (cnt_q == ref_q) ? match_q + 3'd1 : 3'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_ACQUIRE;
          match_d = 3'd0;
        end
      end

      ST_ACQUIRE: begin
        if (tick) begin
          if (!meas_valid) begin
            match_d = 3'd0;
          end else begin
            ref_d   = cnt_q;
            match_d = match_next;
            if (match_next >= LOCK_N) begin
              state_d  = ST_LOCKED;
              period_d = cnt_q;
            end
          end
        end
      end

      ST_LOCKED: begin
        if (tick && (!meas_valid || (cnt_q != period_q))) begin
          state_d = ST_ERROR;
        end
      end

      ST_ERROR: begin
        if (tick && meas_valid) begin
          state_d = ST_ACQUIRE;
          ref_d   = cnt_q;
          match_d = 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef TICK_MON_TIMEOUT_EN
    if (timeout) begin
      state_d = ST_IDLE;
    end
    lost_d = timeout;
`endif

    // Status flags are registered copies of the state being entered.
    locked_d = (state_d == ST_LOCKED);
    err_d    = (state_d == ST_ERROR);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      match_q  <= 3'd0;
      period_q <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      period_q <= period_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign mon.locked     = locked_q;
  assign mon.period_err = err_q;
  assign mon.period_out = period_q;

`ifdef TICK_MON_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lost_q <= 1'b0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign mon.lost = lost_q;
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// Scoreboard bench for tick_period_monitor: directed scenarios then random tick streams,
// checked against a timestamp-based model of the period/lock rules.
module tb_tick_period_monitor;

  localparam int CNT_W      = 4;
  localparam int LOCK_COUNT = 3;
  localparam int MAX        = (1 << CNT_W) - 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   failures = 0;

  tick_period_monitor_if #(.CNT_W(CNT_W)) mon_if ();

  tick_period_monitor #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .mon    (mon_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: works from tick timestamps, not a counter.
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_ERR} mode_e;
  mode_e m_mode;
  int    m_last, m_ref, m_match, m_period;
  bit    m_lost;

  typedef struct {
    int cyc;
    bit locked;
    bit err;
    int period;
    bit lost;
  } exp_t;
  exp_t sb_q[$];

  function automatic void model_reset();
    m_mode = M_IDLE; m_last = 0; m_ref = 0; m_match = 0; m_period = 0; m_lost = 0;
  endfunction

  function automatic void model_edge(input bit t, input int e);
    int elapsed, m;
    bit valid;
    m_lost = 0;
    if (m_mode == M_IDLE) begin
      if (t) begin
        m_mode = M_ACQ; m_match = 0; m_last = e;
      end
      return;
    end
    elapsed = e - m_last;
    m       = (elapsed > MAX) ? MAX : elapsed;
    valid   = (m < MAX);
    if (t) begin
      case (m_mode)
        M_ACQ: begin
          if (!valid) m_match = 0;
          else begin
            if (m == m_ref) m_match++;
            else begin m_ref = m; m_match = 1; end
            if (m_match >= LOCK_COUNT) begin m_mode = M_LOCK; m_period = m_ref; end
          end
        end
        M_LOCK: if (m != m_period) m_mode = M_ERR;
        M_ERR:  if (valid) begin m_mode = M_ACQ; m_ref = m; m_match = 1; end
        default: ;
      endcase
      m_last = e;
    end
`ifdef TICK_MON_TIMEOUT_EN
    else if (elapsed == MAX - 1) begin
      m_mode = M_IDLE; m_lost = 1;
    end
`endif
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the coming edge.
  task automatic step(input bit t);
    exp_t x;
    int e;
    mon_if.tick_in = t;
    e = cyc + 1;
    model_edge(t, e);
    x.cyc = e; x.locked = (m_mode == M_LOCK); x.err = (m_mode == M_ERR);
    x.period = m_period; x.lost = m_lost;
    sb_q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic tick_gap(input int p);
    repeat (p - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_locked"}, mon_if.locked, 0);
    check({tag, "_err"}, mon_if.period_err, 0);
    check({tag, "_period"}, mon_if.period_out, 0);
`ifdef TICK_MON_TIMEOUT_EN
    check({tag, "_lost"}, mon_if.lost, 0);
`endif
  endtask

  // Asserts reset between clock edges and checks outputs clear without an edge.
  task automatic async_reset(input string tag);
    #4;
    mon_if.tick_in = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops and compares whatever is due at each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #4;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        x = sb_q.pop_front();
        check("sb_order", x.cyc, cyc);
        check("sb_locked", mon_if.locked, x.locked);
        check("sb_err", mon_if.period_err, x.err);
        check("sb_period", mon_if.period_out, x.period);
`ifdef TICK_MON_TIMEOUT_EN
        check("sb_lost", mon_if.lost, x.lost);
`endif
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pats[6];
    mon_if.tick_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;

    // Tick every 3 cycles from release: locks after the 4th tick.
    step(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick_gap(3);
      if (i == 1) check("p3_prelock", mon_if.locked, 0);
    end
    check("p3_locked", mon_if.locked, 1);
    check("p3_period", mon_if.period_out, 3);
    check("p3_err", mon_if.period_err, 0);

    // One long period breaks lock; three ticks at period 4 relock.
    tick_gap(4);
    check("p4_err", mon_if.period_err, 1);
    check("p4_unlock", mon_if.locked, 0);
    tick_gap(4);
    check("p4_acq_err", mon_if.period_err, 0);
    tick_gap(4);
    tick_gap(4);
    check("p4_locked", mon_if.locked, 1);
    check("p4_period", mon_if.period_out, 4);

    // Async reset while locked, then a fresh IDLE tick is needed.
    async_reset("rst_locked");
    step(1'b0); step(1'b0);
    step(1'b1);
    for (int i = 0; i < 3; i++) tick_gap(2);
    check("relock_period", mon_if.period_out, 2);

    // Periods 3,3,5,3,3,3: lock only on the third 3 after the 5.
    async_reset("rst_seq");
    step(1'b1);
    pats = '{3, 3, 5, 3, 3, 3};
    for (int i = 0; i < 6; i++) begin
      tick_gap(pats[i]);
      if (i == 4) check("seq_nolock", mon_if.locked, 0);
    end
    check("seq_locked", mon_if.locked, 1);
    check("seq_period", mon_if.period_out, 3);

    // tick_in held high: period 1, locked after 4 ticks.
    async_reset("rst_hold");
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      if (i == 2) check("hold_prelock", mon_if.locked, 0);
    end
    check("hold_locked", mon_if.locked, 1);
    check("hold_period", mon_if.period_out, 1);

`ifdef TICK_MON_TIMEOUT_EN
    // Ticks stop while locked: one lost pulse as the count saturates.
    async_reset("rst_to");
    step(1'b1);
    for (int i = 0; i < 3; i++) tick_gap(3);
    repeat (MAX - 1) step(1'b0);
    check("to_lost", mon_if.lost, 1);
    check("to_unlock", mon_if.locked, 0);
    step(1'b0);
    check("to_lost_once", mon_if.lost, 0);
`else
    // Ticks stop while locked: count saturates, next tick is invalid and flags an error.
    async_reset("rst_sat");
    step(1'b1);
    for (int i = 0; i < 3; i++) tick_gap(3);
    tick_gap(MAX + 4);
    check("sat_err", mon_if.period_err, 1);
`endif

    // Random tick streams with occasional long gaps, bursts and resets.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        async_reset("rst_rand");
      end else if (r < 24) begin
        int p;
        p = $urandom_range(1, 6);
        repeat ($urandom_range(1, 6)) tick_gap(p);
      end else if (r < 32) begin
        tick_gap($urandom_range(1, 8));
      end else if (r < 36) begin
        tick_gap($urandom_range(MAX - 2, MAX + 5));
      end else begin
        repeat (5) step(1'($urandom_range(0, 1)));
      end
    end

    step(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
